// File: rtl/mig_word_bridge_pkg.sv
// rtl/mig_word_bridge_pkg.sv - shared MIG UI constants, state encoding and lane helpers
package mig_pkg;

  localparam logic [2:0] APP_CMD_READ  = 3'b001;
  localparam logic [2:0] APP_CMD_WRITE = 3'b000;

  localparam int LINE_BYTES = 16;
  localparam int LANES      = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_CMD  = 2'd1,
    RD_WAIT = 2'd2,
    WR      = 2'd3
  } state_e;

  // Low word-address bits select the 32-bit lane inside a 128-bit line.
  function automatic logic [1:0] word_lane(input logic [1:0] word_addr_lo);
    return word_addr_lo;
  endfunction

  // MIG mask polarity: 1 = byte not written, so untouched lanes stay all ones.
  function automatic logic [15:0] lane_wdf_mask(input logic [1:0] lane, input logic [3:0] wmask);
    logic [15:0] m;
    m = '1;
    m[{lane, 2'b00} +: 4] = ~wmask;
    return m;
  endfunction

  function automatic logic [31:0] lane_word(input logic [127:0] line, input logic [1:0] lane);
    return line[{lane, 5'b00000} +: 32];
  endfunction

endpackage

// File: rtl/mig_word_bridge_if.sv
// rtl/mig_word_bridge_if.sv - JOP word request side and MIG UI side of the bridge
interface mig_word_bridge_if #(
  parameter int WORD_ADDR_WIDTH = 26,
  parameter int APP_ADDR_WIDTH  = 28
);
  logic                       calib_done;
  logic                       cmd_valid;
  logic                       cmd_ready;
  logic                       cmd_write;
  logic [WORD_ADDR_WIDTH-1:0] cmd_addr;
  logic [31:0]                cmd_wdata;
  logic [3:0]                 cmd_wmask;
  logic                       rsp_valid;
  logic [31:0]                rsp_rdata;
  logic                       app_en;
  logic [2:0]                 app_cmd;
  logic [APP_ADDR_WIDTH-1:0]  app_addr;
  logic                       app_rdy;
  logic                       app_wdf_wren;
  logic                       app_wdf_end;
  logic [127:0]               app_wdf_data;
  logic [15:0]                app_wdf_mask;
  logic                       app_wdf_rdy;
  logic                       app_rd_data_valid;
  logic [127:0]               app_rd_data;
  logic                       app_rd_data_end;
  logic                       err_stray_rd;

  modport master (
    input  calib_done, cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wmask,
    input  app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data, app_rd_data_end,
    output cmd_ready, rsp_valid, rsp_rdata,
    output app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask,
    output err_stray_rd
  );

  modport slave (
    output calib_done, cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wmask,
    output app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data, app_rd_data_end,
    input  cmd_ready, rsp_valid, rsp_rdata,
    input  app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask,
    input  err_stray_rd
  );
endinterface

// File: rtl/mig_word_bridge_lane_mux.sv
// rtl/mig_word_bridge_lane_mux.sv - word-to-line write insert, mask build and read lane extract
module mig_lane_mux
  import mig_pkg::*;
(
  input  logic [1:0]   i_wr_lane,
  input  logic [31:0]  i_wdata,
  input  logic [3:0]   i_wmask,
  input  logic [1:0]   i_rd_lane,
  input  logic [127:0] i_rd_line,
  output logic [127:0] o_wr_line,
  output logic [15:0]  o_wr_mask,
  output logic [31:0]  o_rd_word
);

  // Data is replicated into every lane; the mask alone decides which bytes land.
  assign o_wr_line = {LANES{i_wdata}};
  assign o_wr_mask = lane_wdf_mask(i_wr_lane, i_wmask);
  assign o_rd_word = lane_word(i_rd_line, i_rd_lane);

endmodule

// File: rtl/mig_word_bridge.sv
// rtl/mig_word_bridge.sv - one-outstanding 32-bit word to 128-bit MIG UI line bridge
module mig_word_bridge
  import mig_pkg::*;
#(
  parameter int WORD_ADDR_WIDTH = 26,
  parameter int APP_ADDR_WIDTH  = 28
) (
  input  logic               clk,
  input  logic               resetn,
  mig_word_bridge_if.master  bus
);

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_RD_CMD  = RD_CMD;
  localparam logic [1:0] S_RD_WAIT = RD_WAIT;
  localparam logic [1:0] S_WR      = WR;

  logic [1:0]                r_state;
  logic [1:0]                r_lane;
  logic [APP_ADDR_WIDTH-1:0] r_app_addr;
  logic                      r_app_en;
  logic [2:0]                r_app_cmd;
  logic                      r_wdf_wren;
  logic [127:0]              r_wdf_data;
  logic [15:0]               r_wdf_mask;
  logic                      r_cmd_done;
  logic                      r_data_done;
  logic                      r_rsp_valid;
  logic [31:0]               r_rsp_rdata;
  logic                      r_err_stray;

  logic                      w_accept;
  logic [APP_ADDR_WIDTH-1:0] w_line_addr;
  logic [127:0]              w_wr_line;
  logic [15:0]               w_wr_mask;
  logic [31:0]               w_rd_word;
  logic                      w_cmd_done;
  logic                      w_data_done;

  assign bus.cmd_ready = (r_state == S_IDLE) && bus.calib_done;
  assign w_accept      = bus.cmd_valid && bus.cmd_ready;

  // Word address -> byte address -> 16-byte line boundary.
  assign w_line_addr = APP_ADDR_WIDTH'({bus.cmd_addr[WORD_ADDR_WIDTH-1:2], 4'b0000});

  // Done flags also count a handshake completing this very cycle.
  assign w_cmd_done  = r_cmd_done  || (r_app_en   && bus.app_rdy);
  assign w_data_done = r_data_done || (r_wdf_wren && bus.app_wdf_rdy);

  mig_lane_mux u_lane_mux (
    .i_wr_lane (word_lane(bus.cmd_addr[1:0])),
    .i_wdata   (bus.cmd_wdata),
    .i_wmask   (bus.cmd_wmask),
    .i_rd_lane (r_lane),
    .i_rd_line (bus.app_rd_data),
    .o_wr_line (w_wr_line),
    .o_wr_mask (w_wr_mask),
    .o_rd_word (w_rd_word)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_lane      <= '0;
      r_app_addr  <= '0;
      r_app_en    <= 1'b0;
      r_app_cmd   <= APP_CMD_READ;
      r_wdf_wren  <= 1'b0;
      r_wdf_data  <= '0;
      r_wdf_mask  <= 16'hFFFF;
      r_cmd_done  <= 1'b0;
      r_data_done <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_err_stray <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (bus.app_rd_data_valid && (r_state != S_RD_WAIT)) begin
        r_err_stray <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_lane     <= word_lane(bus.cmd_addr[1:0]);
            r_app_addr <= w_line_addr;
            r_app_en   <= 1'b1;
            if (bus.cmd_write) begin
              r_app_cmd   <= APP_CMD_WRITE;
              r_wdf_wren  <= 1'b1;
              r_wdf_data  <= w_wr_line;
              r_wdf_mask  <= w_wr_mask;
              r_cmd_done  <= 1'b0;
              r_data_done <= 1'b0;
              r_state     <= S_WR;
            end else begin
              r_app_cmd <= APP_CMD_READ;
              r_state   <= S_RD_CMD;
            end
          end
        end
        S_RD_CMD: begin
          if (bus.app_rdy) begin
            r_app_en <= 1'b0;
            r_state  <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (bus.app_rd_data_valid) begin
            r_rsp_rdata <= w_rd_word;
            r_rsp_valid <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        S_WR: begin
          // Command and data channels retire independently of each other.
          if (r_app_en && bus.app_rdy) begin
            r_app_en <= 1'b0;
          end
          if (r_wdf_wren && bus.app_wdf_rdy) begin
            r_wdf_wren <= 1'b0;
          end
          r_cmd_done  <= w_cmd_done;
          r_data_done <= w_data_done;
          if (w_cmd_done && w_data_done) begin
            r_cmd_done  <= 1'b0;
            r_data_done <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.app_en       = r_app_en;
  assign bus.app_cmd      = r_app_cmd;
  assign bus.app_addr     = r_app_addr;
  assign bus.app_wdf_wren = r_wdf_wren;
  assign bus.app_wdf_end  = r_wdf_wren;
  assign bus.app_wdf_data = r_wdf_data;
  assign bus.app_wdf_mask = r_wdf_mask;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_rdata    = r_rsp_rdata;
  assign bus.err_stray_rd = r_err_stray;

  // Single-beat lines: every read data beat must also be the last one.
  a_rd_end : assert property (@(posedge clk) disable iff (!resetn)
                              bus.app_rd_data_valid |-> bus.app_rd_data_end);

endmodule

// File: tb/tb_mig_word_bridge.sv
// tb/tb_mig_word_bridge.sv - directed table-driven bench for mig_word_bridge
module tb_mig_word_bridge;

  typedef struct {
    logic         wr;
    logic [25:0]  addr;
    logic [31:0]  wdata;
    logic [3:0]   wmask;
    logic [127:0] line;
    logic [27:0]  exp_addr;
    logic [15:0]  exp_mask;
    logic [31:0]  exp_rdata;
  } vec_t;

  logic clk;
  logic resetn;
  int   errors;
  int   checks;
  vec_t vecs[7];

  mig_word_bridge_if #(.WORD_ADDR_WIDTH(26), .APP_ADDR_WIDTH(28)) bus ();

  mig_word_bridge #(.WORD_ADDR_WIDTH(26), .APP_ADDR_WIDTH(28)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  assign bus.app_rd_data_end = bus.app_rd_data_valid;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = v.wr;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    bus.cmd_wmask = v.wmask;
    #1;
    check("cmd_ready", 128'(bus.cmd_ready), 128'(1));
    step();
    bus.cmd_valid = 1'b0;
    check("app_en_n1", 128'(bus.app_en), 128'(1));
    check("app_addr", 128'(bus.app_addr), 128'(v.exp_addr));
    check("app_cmd", 128'(bus.app_cmd), v.wr ? 128'(3'b000) : 128'(3'b001));
    if (v.wr) begin
      check("wdf_wren", 128'(bus.app_wdf_wren), 128'(1));
      check("wdf_end", 128'(bus.app_wdf_end), 128'(1));
      check("wdf_data", bus.app_wdf_data, {4{v.wdata}});
      check("wdf_mask", 128'(bus.app_wdf_mask), 128'(v.exp_mask));
      step();
      check("wr_rsp_n2", 128'(bus.rsp_valid), 128'(1));
      check("wr_app_en_off", 128'(bus.app_en), 128'(0));
      check("wr_wren_off", 128'(bus.app_wdf_wren), 128'(0));
    end else begin
      step();
      check("rd_app_en_off", 128'(bus.app_en), 128'(0));
      check("rd_rsp_early", 128'(bus.rsp_valid), 128'(0));
      bus.app_rd_data_valid = 1'b1;
      bus.app_rd_data       = v.line;
      step();
      bus.app_rd_data_valid = 1'b0;
      check("rd_rsp_n3", 128'(bus.rsp_valid), 128'(1));
      check("rd_rdata", 128'(bus.rsp_rdata), 128'(v.exp_rdata));
    end
    step();
    check("rsp_pulse_end", 128'(bus.rsp_valid), 128'(0));
  endtask

  initial begin
    errors = 0;
    checks = 0;

    vecs[0] = '{1'b0, 26'h0000005, 32'h0, 4'h0, 128'h44444444_33333333_22222222_11111111,
                28'h0000010, 16'hFFFF, 32'h22222222};
    vecs[1] = '{1'b1, 26'h0000003, 32'hDEADBEEF, 4'b0011, 128'h0,
                28'h0000000, 16'hCFFF, 32'h0};
    vecs[2] = '{1'b0, 26'h3FFFFFF, 32'h0, 4'h0, 128'h0F0F0F0F_CAFEBABE_12345678_9ABCDEF0,
                28'hFFFFFF0, 16'hFFFF, 32'h0F0F0F0F};
    vecs[3] = '{1'b1, 26'h0000008, 32'h12345678, 4'b1111, 128'h0,
                28'h0000020, 16'hFFF0, 32'h0};
    vecs[4] = '{1'b1, 26'h1234566, 32'hA5A55A5A, 4'b0000, 128'h0,
                28'h48D1590, 16'hFFFF, 32'h0};
    vecs[5] = '{1'b0, 26'h0000002, 32'h0, 4'h0, 128'h0F0F0F0F_CAFEBABE_12345678_9ABCDEF0,
                28'h0000000, 16'hFFFF, 32'hCAFEBABE};
    vecs[6] = '{1'b1, 26'h0000001, 32'h0BADF00D, 4'b1010, 128'h0,
                28'h0000000, 16'hFF5F, 32'h0};

    resetn                = 1'b0;
    bus.calib_done        = 1'b0;
    bus.cmd_valid         = 1'b0;
    bus.cmd_write         = 1'b0;
    bus.cmd_addr          = '0;
    bus.cmd_wdata         = '0;
    bus.cmd_wmask         = '0;
    bus.app_rdy           = 1'b1;
    bus.app_wdf_rdy       = 1'b1;
    bus.app_rd_data_valid = 1'b0;
    bus.app_rd_data       = '0;
    step();
    step();
    check("rst_cmd_ready", 128'(bus.cmd_ready), 128'(0));
    check("rst_app_en", 128'(bus.app_en), 128'(0));
    check("rst_app_cmd", 128'(bus.app_cmd), 128'(3'b001));
    check("rst_wdf_mask", 128'(bus.app_wdf_mask), 128'(16'hFFFF));
    check("rst_wren", 128'(bus.app_wdf_wren), 128'(0));
    check("rst_rsp_valid", 128'(bus.rsp_valid), 128'(0));
    check("rst_err", 128'(bus.err_stray_rd), 128'(0));
    resetn = 1'b1;
    step();

    // Requests are held off until calibration completes.
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 26'h0000005;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("precal_ready", 128'(bus.cmd_ready), 128'(0));
      step();
      check("precal_app_en", 128'(bus.app_en), 128'(0));
    end
    bus.calib_done = 1'b1;
    #1;
    check("cal_ready", 128'(bus.cmd_ready), 128'(1));
    step();
    bus.cmd_valid = 1'b0;
    check("cal_app_en", 128'(bus.app_en), 128'(1));
    check("cal_app_addr", 128'(bus.app_addr), 128'(28'h0000010));
    step();
    bus.app_rd_data_valid = 1'b1;
    bus.app_rd_data       = vecs[0].line;
    step();
    bus.app_rd_data_valid = 1'b0;
    check("cal_rdata", 128'(bus.rsp_rdata), 128'(32'h22222222));
    check("cal_rsp", 128'(bus.rsp_valid), 128'(1));
    step();

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i]);
    end

    // Write whose data channel accepts three cycles after the command channel.
    bus.app_wdf_rdy = 1'b0;
    bus.cmd_valid   = 1'b1;
    bus.cmd_write   = 1'b1;
    bus.cmd_addr    = 26'h0000004;
    bus.cmd_wdata   = 32'h55AA55AA;
    bus.cmd_wmask   = 4'b1111;
    step();
    bus.cmd_valid = 1'b0;
    check("dly_app_en_n1", 128'(bus.app_en), 128'(1));
    check("dly_wren_n1", 128'(bus.app_wdf_wren), 128'(1));
    for (int i = 0; i < 3; i++) begin
      step();
      check("dly_app_en_off", 128'(bus.app_en), 128'(0));
      check("dly_wren_held", 128'(bus.app_wdf_wren), 128'(1));
      check("dly_data_stable", bus.app_wdf_data, {4{32'h55AA55AA}});
      check("dly_mask_stable", 128'(bus.app_wdf_mask), 128'(16'hFFF0));
      check("dly_no_rsp", 128'(bus.rsp_valid), 128'(0));
    end
    bus.app_wdf_rdy = 1'b1;
    step();
    check("dly_rsp", 128'(bus.rsp_valid), 128'(1));
    check("dly_wren_off", 128'(bus.app_wdf_wren), 128'(0));
    step();
    check("dly_rsp_end", 128'(bus.rsp_valid), 128'(0));

    // Read data arriving while idle is a protocol error and is dropped.
    bus.app_rd_data_valid = 1'b1;
    bus.app_rd_data       = 128'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC;
    step();
    bus.app_rd_data_valid = 1'b0;
    check("stray_err", 128'(bus.err_stray_rd), 128'(1));
    check("stray_no_rsp", 128'(bus.rsp_valid), 128'(0));
    step();
    check("stray_no_rsp2", 128'(bus.rsp_valid), 128'(0));
    run_vec(vecs[0]);
    check("stray_sticky", 128'(bus.err_stray_rd), 128'(1));

    // Asynchronous reset while waiting for read data.
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 26'h0000005;
    step();
    bus.cmd_valid = 1'b0;
    step();
    check("pre_rst_addr", 128'(bus.app_addr), 128'(28'h0000010));
    #2;
    resetn = 1'b0;
    #1;
    check("arst_cmd_ready", 128'(bus.cmd_ready), 128'(1));
    check("arst_app_addr", 128'(bus.app_addr), 128'(0));
    check("arst_app_cmd", 128'(bus.app_cmd), 128'(3'b001));
    check("arst_wdf_mask", 128'(bus.app_wdf_mask), 128'(16'hFFFF));
    check("arst_wdf_data", bus.app_wdf_data, 128'(0));
    check("arst_rdata", 128'(bus.rsp_rdata), 128'(0));
    check("arst_err", 128'(bus.err_stray_rd), 128'(0));
    check("arst_app_en", 128'(bus.app_en), 128'(0));
    step();
    resetn = 1'b1;
    step();
    run_vec(vecs[0]);
    check("post_rst_err", 128'(bus.err_stray_rd), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mig_word_bridge.md
Name: mig_word_bridge

Overview:
Converts JOP memory-controller 32-bit word requests into single-beat 128-bit MIG 7-series UI transactions (4:1 mode, BL8 x16 = one 128-bit line). Sits directly upstream of the MIG UI in JopDdr3Top, in the ui_clk domain. Drives app_en/app_cmd/app_addr, the write-data FIFO and read-data lane extraction. Exactly one transaction is outstanding at a time.

Parameters:
WORD_ADDR_WIDTH, 26, JOP word-address width
APP_ADDR_WIDTH, 28, MIG app_addr width (byte address)

Ports:
clk  in  1  ui_clk from MIG
resetn  in  1  asynchronous, active-low reset
calib_done  in  1  MIG init_calib_complete
cmd_valid  in  1  word request valid
cmd_ready  out  1  bridge accepts request
cmd_write  in  1  1=write, 0=read
cmd_addr  in  WORD_ADDR_WIDTH  word address
cmd_wdata  in  32  write data
cmd_wmask  in  4  byte enables, 1=write byte
rsp_valid  out  1  one-cycle completion pulse (read or write)
rsp_rdata  out  32  read word; valid with rsp_valid on reads
app_en  out  1  MIG command valid
app_cmd  out  3  001=read, 000=write
app_addr  out  APP_ADDR_WIDTH  line-aligned byte address
app_rdy  in  1  MIG command accept
app_wdf_wren  out  1  write-data valid
app_wdf_end  out  1  equals app_wdf_wren (single beat)
app_wdf_data  out  128  write line
app_wdf_mask  out  16  1=byte NOT written (MIG polarity)
app_wdf_rdy  in  1  write-data accept
app_rd_data_valid  in  1  read line valid
app_rd_data  in  128  read line
app_rd_data_end  in  1  ignored except by protocol assertion
err_stray_rd  out  1  sticky: rd_data_valid seen outside RD_WAIT

Behaviour:
- Reset: state IDLE; cmd_ready, rsp_valid, app_en, app_wdf_wren, app_wdf_end, err_stray_rd = 0; rsp_rdata, app_addr, app_wdf_data, lane = 0; app_cmd = 001; app_wdf_mask = 16'hFFFF.
- cmd_ready = (state==IDLE) && calib_done (combinational). No requests are accepted before calibration.
- Accept on cmd_valid&&cmd_ready in cycle N. Register lane = cmd_addr[1:0]. Register app_addr = {cmd_addr[WORD_ADDR_WIDTH-1:2], 4'b0}, zero-extended to APP_ADDR_WIDTH (byte = word<<2, then line-aligned).
- Write line: cmd_wdata is replicated into all four 32-bit lanes. app_wdf_mask = 16'hFFFF with bits [4*lane+3:4*lane] = ~cmd_wmask. A wmask of 0 yields an all-masked write, which is still issued.
- States:
  - IDLE: on read accept -> RD_CMD; on write accept -> WR.
  - RD_CMD: app_en=1, app_cmd=001 from cycle N+1. Hold until app_rdy, then -> RD_WAIT.
  - RD_WAIT: on app_rd_data_valid, rsp_rdata = app_rd_data[32*lane+:32], rsp_valid=1 next cycle -> IDLE.
  - WR: app_en (cmd 000) and app_wdf_wren/app_wdf_end all asserted from N+1. Each is held independently until its own rdy and then dropped. Track cmd_done and data_done flags. When both are set, or set in the same cycle, pulse rsp_valid next cycle -> IDLE.
- Read latency: minimum accept -> rsp_valid is 3 cycles plus MIG latency. Write minimum is 2 cycles (rdys high at N+1, rsp at N+2).
- Signals held stable while waiting for rdy: app_addr/app_cmd stable while app_en && !app_rdy. wdf data/mask stable while wren && !wdf_rdy.
- calib_done falling mid-transaction: the transaction completes normally. Only new acceptance is blocked.
- app_rd_data_valid while not in RD_WAIT: data discarded, err_stray_rd set (cleared only by reset). Any data still in flight when resetn deasserts is covered by this rule.
- Reset asserted mid-transaction: all state clears immediately (async). Any MIG command/data already handed over is not tracked.

Decomposition:
- Shared package mig_pkg holds:
  - APP_CMD_READ=3'b001, APP_CMD_WRITE=3'b000
  - LINE_BYTES=16, LANES=4
  - state enum {IDLE, RD_CMD, RD_WAIT, WR}
  - address-to-line and lane functions
- Optional sub-module mig_lane_mux holds the combinational lane insert/extract and mask build. Everything else is a single module.

Test Plan:
- calib_done=0 with cmd_valid=1 -> cmd_ready=0, app_en stays 0. Raise calib_done -> accepted next cycle.
- Read addr 0x000005, MIG returns line 0x44444444_33333333_22222222_11111111 -> app_addr=0x0000010, app_cmd=001, rsp_rdata=0x22222222.
- Write addr 0x000003, wdata 0xDEADBEEF, wmask 4'b0011, app_rdy and wdf_rdy high -> app_addr=0x0000000, app_wdf_mask=16'hCFFF, rsp_valid at N+2.
- Write with wdf_rdy delayed 3 cycles after app_rdy -> app_en drops after 1 cycle, wren held 4 cycles with stable data, rsp_valid one cycle after wdf accept.
- app_rd_data_valid pulse in IDLE -> err_stray_rd=1, no rsp_valid. A subsequent read still returns correct data.
- resetn low during RD_WAIT -> all outputs to reset values within the same cycle. After release, a fresh read completes correctly.
